operand_router_pipe: RTL and testbench
======================================

OPERAND_ROUTER_PIPE -- requirements
Module: operand_router_pipe

Interface
REQ-001 SHALL have parameter W, default 24, operand width in bits (legal 4..32).
REQ-002 SHALL have parameter DEPTH, default 2, output buffer entries (power of two, 2..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports A, B, RQ, RD  input  W each  candidate operand sources.
REQ-006 SHALL have ports sel_R, sel_S, sel_I  input  2 each  source selects.
REQ-007 SHALL have ports inv_R, inv_S  input  1 each  invert request for R and S.
REQ-008 SHALL have port in_valid  input  1  upstream request valid.
REQ-009 SHALL have port in_ready  output  1  block can accept a request.
REQ-010 SHALL have ports R, S, I  output  W each  routed operands at buffer head.
REQ-011 SHALL have ports msb_R, msb_S  output  1 each  bit W-1 of R, S.
REQ-012 SHALL have ports cin_R, cin_S  output  1 each  adder carry-in, equal to the captured inv_R, inv_S.
REQ-013 SHALL have port out_valid  output  1  head entry valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts head.
REQ-015 SHALL have port count  output  clog2(DEPTH+1)  current occupancy.

Function
REQ-016 SHALL map sel 00->A, 01->B, 10->RQ, 11->RD for each of sel_R, sel_S, sel_I independently.
REQ-017 SHALL compute R = inv_R ? ~src_R : src_R and S = inv_S ? ~src_S : src_S (bitwise), and I = src_I, never inverted.
REQ-018 SHALL compute entries at push time; R, S, I, msb_*, cin_* SHALL be stored together as one entry and SHALL NOT change while that entry is at the head.
REQ-019 SHALL push when in_valid && in_ready; SHALL pop when out_valid && out_ready.
REQ-020 SHALL drive in_ready = (count < DEPTH), from registered state only, with no combinational path from out_ready.
REQ-021 SHALL drive out_valid = (count != 0), registered.
REQ-022 SHALL present a pushed entry at the outputs on the cycle after the push edge when empty (latency 1 cycle).
REQ-023 SHALL deliver entries in strict push order; write and read pointers wrap modulo DEPTH.
REQ-024 SHALL, on simultaneous push and pop with 0 < count < DEPTH, hold count unchanged and advance both pointers.
REQ-025 SHALL, at count == DEPTH, ignore in_valid because in_ready is low; a simultaneous pop SHALL lower count to DEPTH-1 and raise in_ready the next cycle.
REQ-026 SHALL, at count == 0, ignore out_ready; a push SHALL NOT bypass combinationally to the outputs.
REQ-027 SHALL drive R, S, I, msb_*, cin_* to all-zero whenever out_valid is low.
REQ-028 SHALL treat occupancy as states EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH); transitions only by +1 (push only), -1 (pop only), or 0 (both or neither).

Reset
REQ-029 SHALL, with rst_n low at a clock edge, set count=0, pointers=0, out_valid=0, in_ready=1 on the following cycle, with all data outputs 0.
REQ-030 SHALL, on reset asserted mid-operation, discard all buffered entries; no entry SHALL appear after reset deasserts.
REQ-031 SHALL ignore in_valid and out_ready on any cycle with rst_n low.

Verification
REQ-032 Reset then single push (W=24, A=0x123456, sel_R=00, inv_R=1, sel_S=11, RD=0x000001, sel_I=10, RQ=0x800000), out_ready=1 -> next cycle R=0xEDCBA9, msb_R=1, cin_R=1, S=0x000001, msb_S=0, I=0x800000, out_valid=1; following cycle out_valid=0 and outputs 0.
REQ-033 DEPTH=2, out_ready=0, push 3 distinct requests back-to-back -> count 1 then 2, in_ready=0 after the second push, third not accepted; release out_ready -> first two drain in order.
REQ-034 Full buffer with in_valid=1, out_ready=1 held -> one pop per cycle, in_ready high the cycle after the first pop, order preserved through pointer wrap over 10 requests.
REQ-035 count=1, simultaneous push and pop -> count stays 1, head shows the new entry next cycle.
REQ-036 count=2, rst_n low for one cycle -> count=0, out_valid=0, in_ready=1, all outputs 0; no stale entry emerges afterwards.
REQ-037 All 4x4x4 select combinations with inv_R/inv_S toggled, W=8 and W=24 -> outputs match the REQ-016/017 model every pop.

Source files
------------

// File: rtl/operand_router_pipe.sv
// Selects and optionally inverts three operands per request, queues them in a DEPTH-entry buffer.
// One-cycle push-to-head latency; in_ready depends only on registered occupancy, never on out_ready.
module operand_router_pipe #(
  parameter int W     = 24,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [W-1:0]               A,
  input  logic [W-1:0]               B,
  input  logic [W-1:0]               RQ,
  input  logic [W-1:0]               RD,
  input  logic [1:0]                 sel_R,
  input  logic [1:0]                 sel_S,
  input  logic [1:0]                 sel_I,
  input  logic                       inv_R,
  input  logic                       inv_S,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [W-1:0]               R,
  output logic [W-1:0]               S,
  output logic [W-1:0]               I,
  output logic                       msb_R,
  output logic                       msb_S,
  output logic                       cin_R,
  output logic                       cin_S,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] s;
    logic [W-1:0] i;
    logic         cin_r;
    logic         cin_s;
  } entry_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} occ_e;

  function automatic logic [W-1:0] f_pick(input logic [1:0] sel, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [W-1:0] rq,
                                          input logic [W-1:0] rd);
    case (sel)
      2'b00:   f_pick = a;
      2'b01:   f_pick = b;
      2'b10:   f_pick = rq;
      default: f_pick = rd;
    endcase
  endfunction

  occ_e            r_state;
  occ_e            w_state_nxt;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_nxt;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  entry_t          r_mem [DEPTH];
  entry_t          w_entry;
  entry_t          w_head;
  logic            w_push;
  logic            w_pop;
  logic [W-1:0]    w_src_r;
  logic [W-1:0]    w_src_s;

  assign in_ready  = (r_state != ST_FULL);
  assign out_valid = (r_state != ST_EMPTY);
  assign count     = r_count;

  assign w_src_r       = f_pick(sel_R, A, B, RQ, RD);
  assign w_src_s       = f_pick(sel_S, A, B, RQ, RD);
  assign w_entry.r     = inv_R ? ~w_src_r : w_src_r;
  assign w_entry.s     = inv_S ? ~w_src_s : w_src_s;
  assign w_entry.i     = f_pick(sel_I, A, B, RQ, RD);
  assign w_entry.cin_r = inv_R;
  assign w_entry.cin_s = inv_S;

  always_comb begin
    w_push      = in_valid && in_ready;
    w_pop       = out_valid && out_ready;
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
    w_state_nxt = ST_PARTIAL;
    if (w_count_nxt == '0)
      w_state_nxt = ST_EMPTY;
    else if (w_count_nxt == FULL_CNT)
      w_state_nxt = ST_FULL;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_EMPTY;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: pointers and occupancy decide what is visible.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  assign w_head = out_valid ? r_mem[r_rd_ptr] : '0;
  assign R      = w_head.r;
  assign S      = w_head.s;
  assign I      = w_head.i;
  assign msb_R  = w_head.r[W-1];
  assign msb_S  = w_head.s[W-1];
  assign cin_R  = w_head.cin_r;
  assign cin_S  = w_head.cin_s;

endmodule

// File: tb/tb_operand_router_pipe.sv
// Drives a W=24 and a W=8 instance in lockstep and checks both against a queue-based reference model.
module tb_operand_router_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] A, B, RQ, RD;
  logic [1:0]  sel_R, sel_S, sel_I;
  logic        inv_R, inv_S, in_valid, out_ready;

  logic        in_ready, out_valid, msb_R, msb_S, cin_R, cin_S;
  logic [23:0] R, S, I;
  logic [1:0]  count;

  logic        in_ready8, out_valid8, msb_R8, msb_S8, cin_R8, cin_S8;
  logic [7:0]  R8, S8, I8;
  logic [1:0]  count8;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [23:0] r, s, i;
    logic        cr, cs;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  operand_router_pipe #(.W(24), .DEPTH(2)) u_dut24 (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .RQ(RQ), .RD(RD),
    .sel_R(sel_R), .sel_S(sel_S), .sel_I(sel_I), .inv_R(inv_R), .inv_S(inv_S),
    .in_valid(in_valid), .in_ready(in_ready), .R(R), .S(S), .I(I),
    .msb_R(msb_R), .msb_S(msb_S), .cin_R(cin_R), .cin_S(cin_S),
    .out_valid(out_valid), .out_ready(out_ready), .count(count)
  );

  operand_router_pipe #(.W(8), .DEPTH(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .A(A[7:0]), .B(B[7:0]), .RQ(RQ[7:0]), .RD(RD[7:0]),
    .sel_R(sel_R), .sel_S(sel_S), .sel_I(sel_I), .inv_R(inv_R), .inv_S(inv_S),
    .in_valid(in_valid), .in_ready(in_ready8), .R(R8), .S(S8), .I(I8),
    .msb_R(msb_R8), .msb_S(msb_S8), .cin_R(cin_R8), .cin_S(cin_S8),
    .out_valid(out_valid8), .out_ready(out_ready), .count(count8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] pick(input logic [1:0] s);
    case (s)
      2'd0:    return A;
      2'd1:    return B;
      2'd2:    return RQ;
      default: return RD;
    endcase
  endfunction

  function automatic exp_t model();
    exp_t e;
    e.r  = inv_R ? ~pick(sel_R) : pick(sel_R);
    e.s  = inv_S ? ~pick(sel_S) : pick(sel_S);
    e.i  = pick(sel_I);
    e.cr = inv_R;
    e.cs = inv_S;
    return e;
  endfunction

  task automatic compare();
    exp_t e;
    logic v;
    v = (q.size() != 0);
    if (v) e = q[0];
    else begin
      e.r = '0; e.s = '0; e.i = '0; e.cr = 1'b0; e.cs = 1'b0;
    end
    check("out_valid", out_valid, v);
    check("in_ready", in_ready, q.size() < 2);
    check("count", count, q.size());
    check("R", R, e.r);
    check("S", S, e.s);
    check("I", I, e.i);
    check("msb_R", msb_R, e.r[23]);
    check("msb_S", msb_S, e.s[23]);
    check("cin_R", cin_R, e.cr);
    check("cin_S", cin_S, e.cs);
    check("out_valid8", out_valid8, v);
    check("in_ready8", in_ready8, q.size() < 2);
    check("count8", count8, q.size());
    check("R8", R8, e.r[7:0]);
    check("S8", S8, e.s[7:0]);
    check("I8", I8, e.i[7:0]);
    check("msb_R8", msb_R8, e.r[7]);
    check("msb_S8", msb_S8, e.s[7]);
    check("cin_R8", cin_R8, e.cr);
    check("cin_S8", cin_S8, e.cs);
  endtask

  // One clock: apply controls, check current head against the model, then advance both.
  task automatic cyc(input logic v, input logic rdy, input logic rs);
    logic do_push, do_pop;
    in_valid  = v;
    out_ready = rdy;
    rst_n     = rs;
    #1;
    compare();
    if (!rs) q.delete();
    else begin
      do_pop  = rdy && (q.size() != 0);
      do_push = v && (q.size() < 2);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(model());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req();
    A = 24'($urandom); B = 24'($urandom); RQ = 24'($urandom); RD = 24'($urandom);
    sel_R = 2'($urandom_range(0, 3)); sel_S = 2'($urandom_range(0, 3));
    sel_I = 2'($urandom_range(0, 3));
    inv_R = 1'($urandom_range(0, 1)); inv_S = 1'($urandom_range(0, 1));
  endtask

  initial begin
    A = '0; B = '0; RQ = '0; RD = '0;
    sel_R = '0; sel_S = '0; sel_I = '0; inv_R = 0; inv_S = 0;
    in_valid = 0; out_ready = 0; rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    cyc(0, 0, 0);
    cyc(0, 1, 1);

    // Directed single push with known operand values
    A = 24'h123456; B = 24'h0; sel_R = 2'b00; inv_R = 1'b1;
    sel_S = 2'b11; RD = 24'h000001; inv_S = 1'b0; sel_I = 2'b10; RQ = 24'h800000;
    cyc(1, 1, 1);
    check("d_R", R, 24'hEDCBA9);
    check("d_msb_R", msb_R, 1);
    check("d_cin_R", cin_R, 1);
    check("d_S", S, 24'h000001);
    check("d_msb_S", msb_S, 0);
    check("d_I", I, 24'h800000);
    check("d_valid", out_valid, 1);
    cyc(0, 1, 1);
    check("d_empty_valid", out_valid, 0);
    check("d_empty_R", R, 0);
    check("d_empty_cin", cin_R, 0);

    // Fill with out_ready low; third request must be refused
    rand_req(); cyc(1, 0, 1);
    check("f_count1", count, 1);
    rand_req(); cyc(1, 0, 1);
    check("f_count2", count, 2);
    check("f_in_ready", in_ready, 0);
    rand_req(); cyc(1, 0, 1);
    check("f_count_hold", count, 2);
    repeat (3) cyc(0, 1, 1);

    // Full buffer, both handshakes held high, through pointer wrap
    rand_req(); cyc(1, 0, 1);
    rand_req(); cyc(1, 0, 1);
    for (int k = 0; k < 10; k++) begin
      rand_req(); cyc(1, 1, 1);
    end
    repeat (3) cyc(0, 1, 1);

    // Simultaneous push and pop at count 1
    rand_req(); cyc(1, 0, 1);
    rand_req(); cyc(1, 1, 1);
    check("sp_count", count, 1);
    repeat (2) cyc(0, 1, 1);

    // Reset while full; nothing stale must come out afterwards
    rand_req(); cyc(1, 0, 1);
    rand_req(); cyc(1, 0, 1);
    rand_req(); cyc(1, 1, 0);
    check("rst_count", count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    repeat (3) cyc(0, 1, 1);

    // Exhaustive select and invert sweep
    for (int sr = 0; sr < 4; sr++)
      for (int ss = 0; ss < 4; ss++)
        for (int si = 0; si < 4; si++)
          for (int iv = 0; iv < 4; iv++) begin
            rand_req();
            sel_R = 2'(sr); sel_S = 2'(ss); sel_I = 2'(si);
            inv_R = iv[0]; inv_S = iv[1];
            cyc(1, 1, 1);
          end
    repeat (3) cyc(0, 1, 1);

    // Random traffic with occasional reset
    for (int k = 0; k < 1500; k++) begin
      rand_req();
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 49) != 0));
    end
    repeat (3) cyc(0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
